// File: rtl/riscv_nn_wb_arbiter.sv
// riscv_nn_wb_arbiter: merges ALU, LSU and buffered NN results onto two register-file write ports and tracks pending NN writes.
module riscv_nn_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  nn_valid_i,
  output logic                  nn_ready_o,
  input  logic [ADDR_WIDTH-1:0] nn_waddr_i,
  input  logic [DATA_WIDTH-1:0] nn_wdata_i,
  input  logic                  issue_i,
  input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_b_i,
  input  logic [ADDR_WIDTH-1:0] chk_addr_c_i,
  output logic                  hazard_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NREG = 2 ** ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic push, pop, empty;
  logic [ADDR_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_d;
  logic we_a_d, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_d, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_d, wdata_b_d;
  assign empty = cnt_q == '0;
  assign nn_ready_o = !cnt_q[PW];
  assign push = nn_valid_i && nn_ready_o;
  assign head_a = fa_q[rp_q];
  assign head_d = fd_q[rp_q];
  // Head takes B when the LSU is idle, else A; never alongside a same-address write on the other port.
  assign pop = !empty && (!lsu_valid_i ? !(alu_valid_i && alu_waddr_i == head_a)
                                       : (!alu_valid_i && lsu_waddr_i != head_a));
  assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign we_a_d = alu_valid_i || (pop && lsu_valid_i);
  assign waddr_a_d = alu_valid_i ? alu_waddr_i : head_a;
  assign wdata_a_d = alu_valid_i ? alu_wdata_i : head_d;
  assign we_b_d = lsu_valid_i || pop;
  assign waddr_b_d = lsu_valid_i ? lsu_waddr_i : head_a;
  assign wdata_b_d = lsu_valid_i ? lsu_wdata_i : head_d;
  assign hazard_o = busy_q[chk_addr_a_i] | busy_q[chk_addr_b_i] | busy_q[chk_addr_c_i];
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_a] = 1'b0;
    if (issue_i && issue_waddr_i != '0) busy_d[issue_waddr_i] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= nn_waddr_i;
      fd_q[wp_q] <= nn_wdata_i;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      busy_q <= '0;
      we_a_o <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
    end else begin
      wp_q <= push ? wp_q + PW'(1) : wp_q;
      rp_q <= pop ? rp_q + PW'(1) : rp_q;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      we_a_o <= we_a_d;
      waddr_a_o <= waddr_a_d;
      wdata_a_o <= wdata_a_d;
      we_b_o <= we_b_d;
      waddr_b_o <= waddr_b_d;
      wdata_b_o <= wdata_b_d;
    end
  end
  // Re-issuing a busy register is only legal when its pending write commits this cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_i && busy_q[issue_waddr_i] && !(pop && head_a == issue_waddr_i)));
endmodule

// File: tb/tb_riscv_nn_wb_arbiter.sv
// tb_riscv_nn_wb_arbiter: directed scoreboard bench for the write-back arbiter (FP register file configuration).
module tb_riscv_nn_wb_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic alu_valid_i = 0, lsu_valid_i = 0, nn_valid_i = 0, issue_i = 0;
  logic [AW-1:0] alu_waddr_i = 0, lsu_waddr_i = 0, nn_waddr_i = 0, issue_waddr_i = 0;
  logic [AW-1:0] chk_addr_a_i = 0, chk_addr_b_i = 0, chk_addr_c_i = 0;
  logic [DW-1:0] alu_wdata_i = 0, lsu_wdata_i = 0, nn_wdata_i = 0;
  logic nn_ready_o, hazard_o, we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;
  wr_t qa[$], qb[$];
  int tests = 0, fails = 0;
  riscv_nn_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .nn_valid_i(nn_valid_i), .nn_ready_o(nn_ready_o), .nn_waddr_i(nn_waddr_i), .nn_wdata_i(nn_wdata_i),
    .issue_i(issue_i), .issue_waddr_i(issue_waddr_i),
    .chk_addr_a_i(chk_addr_a_i), .chk_addr_b_i(chk_addr_b_i), .chk_addr_c_i(chk_addr_c_i),
    .hazard_o(hazard_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_ports();
    wr_t e;
    if (we_a_o === 1'b1) begin
      chk("a_write_expected", 64'(qa.size() != 0), 64'(1));
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_addr", 64'(waddr_a_o), 64'(e.a));
        chk("a_data", 64'(wdata_a_o), 64'(e.d));
      end
    end
    if (we_b_o === 1'b1) begin
      chk("b_write_expected", 64'(qb.size() != 0), 64'(1));
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_addr", 64'(waddr_b_o), 64'(e.a));
        chk("b_data", 64'(wdata_b_o), 64'(e.d));
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    check_ports();
  endtask
  task automatic alu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    alu_valid_i = v; alu_waddr_i = a; alu_wdata_i = d;
    if (v) qa.push_back('{a, d});
  endtask
  task automatic lsu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d;
    if (v) qb.push_back('{a, d});
  endtask
  task automatic nn(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    nn_valid_i = v; nn_waddr_i = a; nn_wdata_i = d;
  endtask
  task automatic queues_empty(input string tag);
    chk({tag, "_qa_empty"}, 64'(qa.size()), 64'(0));
    chk({tag, "_qb_empty"}, 64'(qb.size()), 64'(0));
  endtask
  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_we_a", 64'(we_a_o), 64'(0));
    chk("rst_we_b", 64'(we_b_o), 64'(0));
    chk("rst_waddr", 64'({waddr_a_o, waddr_b_o}), 64'(0));
    chk("rst_wdata", {wdata_a_o, wdata_b_o}, 64'(0));
    chk("rst_hazard", 64'(hazard_o), 64'(0));
    chk("rst_ready", 64'(nn_ready_o), 64'(1));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    tick();
    // isolated ALU write
    alu(1, 5, 32'hDEADBEEF);
    tick();
    chk("alu_we_a", 64'(we_a_o), 64'(1));
    chk("alu_no_we_b", 64'(we_b_o), 64'(0));
    alu(0, 0, 0);
    tick();
    chk("alu_we_a_drop", 64'(we_a_o), 64'(0));
    // NN round trip
    chk_addr_a_i = 7;
    chk("rt_hazard_pre", 64'(hazard_o), 64'(0));
    issue_i = 1; issue_waddr_i = 7;
    tick();
    issue_i = 0;
    chk("rt_hazard_set", 64'(hazard_o), 64'(1));
    nn(1, 7, 32'h1234);
    qb.push_back('{7, 32'h1234});
    tick();
    nn(0, 0, 0);
    chk("rt_no_bypass", 64'(we_b_o), 64'(0));
    chk("rt_hazard_held", 64'(hazard_o), 64'(1));
    tick();
    chk("rt_we_b", 64'(we_b_o), 64'(1));
    chk("rt_hazard_clear", 64'(hazard_o), 64'(0));
    queues_empty("rt");
    // full FIFO while both owners write every cycle
    for (int i = 0; i < 4; i++) begin
      chk("full_ready_before", 64'(nn_ready_o), 64'(1));
      alu(1, 20, 32'h100 + i);
      lsu(1, 21, 32'h200 + i);
      nn(1, AW'(10 + i), 32'hA0 + i);
      tick();
    end
    chk("full_ready_low", 64'(nn_ready_o), 64'(0));
    lsu(0, 0, 0);
    nn(1, 30, 32'hFF);
    alu(1, 20, 32'h300);
    for (int i = 0; i < 4; i++) qb.push_back('{AW'(10 + i), 32'hA0 + i});
    tick();
    nn(0, 0, 0);
    chk("full_drain_b", 64'(we_b_o), 64'(1));
    chk("full_ready_back", 64'(nn_ready_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      alu(1, 20, 32'h301 + i);
      tick();
      chk("full_drain_each", 64'(we_b_o), 64'(1));
    end
    alu(0, 0, 0);
    tick();
    chk("full_idle_b", 64'(we_b_o), 64'(0));
    queues_empty("full");
    // address conflict: head x9 stalls behind LSU write to x9
    nn(1, 9, 32'h99);
    tick();
    nn(0, 0, 0);
    lsu(1, 9, 32'h55);
    tick();
    chk("conf_stall_a", 64'(we_a_o), 64'(0));
    chk("conf_lsu_b", 64'(we_b_o), 64'(1));
    lsu(0, 0, 0);
    qb.push_back('{9, 32'h99});
    tick();
    chk("conf_drain_b", 64'(we_b_o), 64'(1));
    // head drains on A when LSU busy with a different address
    nn(1, 11, 32'h77);
    tick();
    nn(0, 0, 0);
    lsu(1, 12, 32'h88);
    qa.push_back('{11, 32'h77});
    tick();
    lsu(0, 0, 0);
    chk("drain_a_we", 64'(we_a_o), 64'(1));
    tick();
    queues_empty("conf");
    // set wins over clear on the same register
    chk_addr_a_i = 3;
    issue_i = 1; issue_waddr_i = 3;
    tick();
    issue_i = 0;
    nn(1, 3, 32'h33);
    tick();
    nn(0, 0, 0);
    issue_i = 1; issue_waddr_i = 3;
    qb.push_back('{3, 32'h33});
    tick();
    issue_i = 0;
    chk("sc_commit_b", 64'(we_b_o), 64'(1));
    chk("sc_busy_kept", 64'(hazard_o), 64'(1));
    chk_addr_a_i = 0;
    issue_i = 1; issue_waddr_i = 0;
    tick();
    issue_i = 0;
    chk("x0_never_busy", 64'(hazard_o), 64'(0));
    chk_addr_c_i = 32;
    chk("f0_not_yet", 64'(hazard_o), 64'(0));
    issue_i = 1; issue_waddr_i = 32;
    tick();
    issue_i = 0;
    chk("f0_busy", 64'(hazard_o), 64'(1));
    queues_empty("sc");
    // reset with 3 entries queued and busy bits on x3 and f0
    chk_addr_a_i = 3;
    for (int i = 0; i < 3; i++) begin
      alu(1, 20, 32'h400 + i);
      lsu(1, 21, 32'h500 + i);
      nn(1, AW'(40 + i), 32'hC0 + i);
      tick();
    end
    alu(0, 0, 0); lsu(0, 0, 0); nn(0, 0, 0);
    chk("mr_hazard_pre", 64'(hazard_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mr_we", 64'({we_a_o, we_b_o}), 64'(0));
    chk("mr_hazard", 64'(hazard_o), 64'(0));
    chk("mr_ready", 64'(nn_ready_o), 64'(1));
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_stale", 64'({we_a_o, we_b_o}), 64'(0));
    end
    chk("mr_hazard_after", 64'(hazard_o), 64'(0));
    queues_empty("mr");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
